// File: rtl/hier_child_sequencer.sv
// Per-level launch sequencer: strobes each child's start in index order, waits for its done,
// and reports completion or a per-child timeout to the parent level.
module hier_child_sequencer #(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned IDX_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [IDX_W-1:0]        fail_idx_o,
  output logic [IDX_W-1:0]        active_idx_o,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_CHILDREN - 1);
  // With TIMEOUT=0 this wraps to all-ones, but it is never used because LP_TMO_EN is 0.
  localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               LP_TMO_EN   = (TIMEOUT != 0);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_error;
  logic             w_error_nxt;
  logic [IDX_W-1:0] r_fail_idx;
  logic [IDX_W-1:0] w_fail_idx_nxt;

  logic             w_cur_done;
  logic             w_timeout;
  logic             w_busy;

  // Only the done bit of the child currently awaited is ever looked at.
  always_comb begin
    w_cur_done = 1'b0;
    for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_done = child_done_i[i];
      end
    end
  end

  assign w_timeout = LP_TMO_EN && (r_cnt == LP_TMO_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_error_nxt    = r_error;
    w_fail_idx_nxt = r_fail_idx;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt    = S_LAUNCH;
          w_idx_nxt      = '0;
          w_error_nxt    = 1'b0;
          w_fail_idx_nxt = '0;
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final timeout cycle still counts as success.
        if (w_cur_done) begin
          if (r_idx == LP_LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_LAUNCH;
          end
        end else if (w_timeout) begin
          w_state_nxt    = S_ERR;
          w_error_nxt    = 1'b1;
          w_fail_idx_nxt = r_idx;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
      S_ERR: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_error    <= 1'b0;
      r_fail_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_error    <= w_error_nxt;
      r_fail_idx <= w_fail_idx_nxt;
    end
  end

  assign w_busy = (r_state == S_LAUNCH) || (r_state == S_WAIT);

  always_comb begin
    child_start_o = '0;
    for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
      child_start_o[i] = (r_state == S_LAUNCH) && (r_idx == IDX_W'(i));
    end
  end

  assign busy_o       = w_busy;
  assign done_o       = (r_state == S_DONE);
  assign error_o      = r_error;
  assign fail_idx_o   = r_fail_idx;
  assign active_idx_o = w_busy ? r_idx : '0;

endmodule

// File: tb/tb_hier_child_sequencer.sv
// Directed bench for hier_child_sequencer: a default instance and a TIMEOUT=4 instance share
// the same stimulus; each scenario checks one of them cycle by cycle.
module tb_hier_child_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [4:0] child_done_i;

  logic       d_busy, d_done, d_err;
  logic [2:0] d_fidx, d_aidx;
  logic [4:0] d_start;
  logic       t_busy, t_done, t_err;
  logic [2:0] t_fidx, t_aidx;
  logic [4:0] t_start;

  int n_checks = 0;
  int n_errors = 0;
  int dly[5];

  always #5 clk = ~clk;

  hier_child_sequencer u_dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_o       (d_busy),
    .done_o       (d_done),
    .error_o      (d_err),
    .fail_idx_o   (d_fidx),
    .active_idx_o (d_aidx),
    .child_start_o(d_start),
    .child_done_i (child_done_i)
  );

  hier_child_sequencer #(
    .NUM_CHILDREN(5),
    .TIMEOUT     (4),
    .CNT_W       (8),
    .IDX_W       (3)
  ) u_dut_t4 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_o       (t_busy),
    .done_o       (t_done),
    .error_o      (t_err),
    .fail_idx_o   (t_fidx),
    .active_idx_o (t_aidx),
    .child_start_o(t_start),
    .child_done_i (child_done_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input int obs, input int e_val);
    n_checks++;
    assert (obs === e_val) else begin
      n_errors++;
      $error("FAIL %s @%0d: got %0d want %0d", tag, n, obs, e_val);
    end
  endtask

  task automatic chk_all(input bit sel, input string tag, input int n, input int e_start,
                         input int e_busy, input int e_done, input int e_err, input int e_fidx,
                         input int e_aidx);
    chk({tag, "/start"}, n, sel ? int'(t_start) : int'(d_start), e_start);
    chk({tag, "/busy"},  n, sel ? int'(t_busy)  : int'(d_busy),  e_busy);
    chk({tag, "/done"},  n, sel ? int'(t_done)  : int'(d_done),  e_done);
    chk({tag, "/err"},   n, sel ? int'(t_err)   : int'(d_err),   e_err);
    chk({tag, "/fidx"},  n, sel ? int'(t_fidx)  : int'(d_fidx),  e_fidx);
    chk({tag, "/aidx"},  n, sel ? int'(t_aidx)  : int'(d_aidx),  e_aidx);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    start_i      = 1'b0;
    child_done_i = '0;
    tick();
    tick();
    chk_all(1'b0, "rst_def", 0, 0, 0, 0, 0, 0, 0);
    chk_all(1'b1, "rst_t4", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Child i is done in its dly[i]-th WAIT cycle; n counts edges after start_i is sampled.
  task automatic run_timed(input bit sel, input string tag);
    int launch[5];
    int last;
    launch[0] = 1;
    for (int i = 1; i < 5; i++) launch[i] = launch[i-1] + dly[i-1] + 1;
    last = launch[4] + dly[4];
    start_i      = 1'b1;
    child_done_i = '0;
    for (int n = 1; n <= last + 2; n++) begin
      int e_start;
      int e_aidx;
      tick();
      e_start = 0;
      e_aidx  = 0;
      for (int i = 0; i < 5; i++) begin
        if (n == launch[i]) e_start = 1 << i;
        if (n >= launch[i] && n <= launch[i] + dly[i]) e_aidx = i;
      end
      chk_all(sel, tag, n, e_start, int'(n <= last), int'(n == last + 1), 0, 0, e_aidx);
      child_done_i = '0;
      for (int i = 0; i < 5; i++) begin
        if (n == launch[i] + dly[i]) child_done_i[i] = 1'b1;
        else if (n == launch[i] + 1 && dly[i] > 1) child_done_i = ~(5'b1 << i);
      end
      start_i = (n == 3);
    end
    start_i      = 1'b0;
    child_done_i = '0;
  endtask

  initial begin
    use_defaults();
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk_all(1'b0, "idle_def", n, 0, 0, 0, 0, 0, 0);
      chk_all(1'b1, "idle_t4", n, 0, 0, 0, 0, 0, 0);
    end

    // Every child done one cycle after its strobe: strobes at 1,3,5,7,9, done_o at 11.
    for (int i = 0; i < 5; i++) dly[i] = 1;
    run_timed(1'b0, "fast");
    do_reset();

    // Child 2 answers in its 40th WAIT cycle: 41-cycle gap between strobes 2 and 3.
    dly[2] = 40;
    run_timed(1'b0, "slow2");
    do_reset();

    // Done lands exactly on the counter=TIMEOUT-1 cycle: sequencing continues, no error.
    dly[0] = 4; dly[1] = 1; dly[2] = 4; dly[3] = 1; dly[4] = 4;
    run_timed(1'b1, "collide");
    do_reset();

    // TIMEOUT=4, child 3 never done; a start_i during ERR is ignored.
    start_i = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      int e_start;
      int e_aidx;
      tick();
      e_start = (n <= 7 && n % 2 == 1) ? (1 << ((n - 1) / 2)) : 0;
      e_aidx  = (n > 11) ? 0 : (n <= 7 ? (n - 1) / 2 : 3);
      chk_all(1'b1, "tmo", n, e_start, int'(n <= 11), 0, int'(n >= 12), (n >= 12) ? 3 : 0,
              e_aidx);
      child_done_i = (n == 2 || n == 4 || n == 6) ? 5'(1 << ((n - 2) / 2)) : 5'b0;
      start_i      = (n == 12);
    end
    start_i = 1'b1;
    tick();
    chk_all(1'b1, "tmo_restart", 17, 1, 1, 0, 0, 0, 0);
    start_i = 1'b0;
    do_reset();

    // All done bits held high and start_i held high: back-to-back runs.
    child_done_i = 5'b11111;
    start_i      = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      int m;
      tick();
      m = (n > 12) ? n - 12 : n;
      chk_all(1'b0, "held", n, (m <= 9 && m % 2 == 1) ? (1 << ((m - 1) / 2)) : 0,
              int'(m <= 10), int'(m == 11), 0, 0, (m <= 10) ? (m - 1) / 2 : 0);
      if (n >= 13) start_i = 1'b0;
    end
    do_reset();

    // Reset while waiting on child 1, then a fresh start begins at child 0.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk_all(1'b0, "mid", 1, 1, 1, 0, 0, 0, 0);
    tick();
    child_done_i = 5'b00001;
    tick();
    child_done_i = 5'b00000;
    chk_all(1'b0, "mid", 3, 2, 1, 0, 0, 0, 1);
    tick();
    chk_all(1'b0, "mid", 4, 0, 1, 0, 0, 0, 1);
    rst = 1'b1;
    tick();
    chk_all(1'b0, "mid_rst", 5, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_all(1'b0, "mid_idle", 6, 0, 0, 0, 0, 0, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk_all(1'b0, "mid_restart", 7, 1, 1, 0, 0, 0, 0);
    tick();
    chk_all(1'b0, "mid_restart", 8, 0, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  task automatic use_defaults();
    rst          = 1'b1;
    start_i      = 1'b0;
    child_done_i = '0;
    for (int i = 0; i < 5; i++) dly[i] = 1;
  endtask

endmodule
